// File: rtl/mux_pipe_nto1.sv
// mux_pipe_nto1: pipelined N-to-1 lane mux with stall/flush; define MUX_PIPE_SELCHK_EN to flag out-of-range selects
module mux_pipe_nto1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int STAGES = 1,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    sel_err
);
  localparam int NL = 2**SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
  logic [WIDTH-1:0] lanes [NL];
  logic [WIDTH-1:0] d [STAGES];
  logic             v [STAGES];
  logic             e [STAGES];
  logic             ok;
  logic             e0;
  logic [WIDTH-1:0] d0;
  for (genvar k = 0; k < NL; k++) begin : g_lane
    if (k < NUM_IN) begin : g_real
      assign lanes[k] = in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign lanes[k] = '0;
    end
  end
  // stage-0 candidate: chosen lane, or the out-of-range substitute
  always_comb begin
    ok = {1'b0, sel} < NUM_IN_W;
`ifdef MUX_PIPE_SELCHK_EN
    d0 = ok ? lanes[sel] : '0;
    e0 = !ok;
`else
    d0 = ok ? lanes[sel] : lanes[0];
    e0 = 1'b0;
`endif
  end
  // pipeline registers: flush beats stall, stall beats load; idle input keeps stage-0 data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        v[i] <= 1'b0;
        e[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        v[i] <= 1'b0;
        e[i] <= 1'b0;
      end
    end else if (!stall) begin
      v[0] <= in_valid;
      e[0] <= in_valid & e0;
      if (in_valid) d[0] <= d0;
      for (int i = 1; i < STAGES; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
        e[i] <= e[i-1];
      end
    end
  end
  assign out       = d[STAGES-1];
  assign out_valid = v[STAGES-1];
  assign sel_err   = e[STAGES-1];
endmodule

// File: tb/tb_mux_pipe_nto1.sv
// tb_mux_pipe_nto1: directed checks on three configurations sharing one stimulus
module tb_mux_pipe_nto1;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [127:0] in_data = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
  logic [1:0]   sel = 0;
  logic         in_valid = 0, stall = 0, flush = 0;
  logic [31:0]  o2, o1, o3;
  logic         v2, v1, v3, e2, e1, e3;
  int           total = 0, bad = 0;
  always #5 clk = ~clk;
  mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4), .STAGES(2), .SEL_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o2), .out_valid(v2), .sel_err(e2));
  mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4), .STAGES(1), .SEL_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o1), .out_valid(v1), .sel_err(e1));
  mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(3), .STAGES(2), .SEL_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o3), .out_valid(v3), .sel_err(e3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_out", o2, 0);
    chk("rst_valid", {31'b0, v2}, 0);
    chk("rst_err", {31'b0, e3}, 0);
    tick;
    rst_n = 1;
    sel = 2; in_valid = 1;
    tick;
    in_valid = 0;
    chk("basic_early", {31'b0, v2}, 0);
    chk("basic_s1", o1, 32'hC2);
    tick;
    chk("basic_out", o2, 32'hC2);
    chk("basic_valid", {31'b0, v2}, 1);
    sel = 0; in_valid = 1;
    tick;
    sel = 1;
    tick;
    chk("str_a0", o2, 32'hA0);
    sel = 2;
    tick;
    chk("str_b1", o2, 32'hB1);
    sel = 3;
    tick;
    chk("str_c2", o2, 32'hC2);
    stall = 1; sel = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_out", o2, 32'hC2);
      chk("stall_valid", {31'b0, v2}, 1);
    end
    stall = 0; in_valid = 0;
    tick;
    chk("resume_d3", o2, 32'hD3);
    chk("resume_v", {31'b0, v2}, 1);
    tick;
    chk("no_dup", {31'b0, v2}, 0);
    sel = 0; in_valid = 1;
    tick;
    sel = 1;
    tick;
    chk("pre_flush", o2, 32'hA0);
    stall = 1; flush = 1; sel = 2;
    tick;
    chk("flush_out", o2, 0);
    chk("flush_valid", {31'b0, v2}, 0);
    stall = 0; flush = 0; in_valid = 0;
    tick;
    chk("flush_gone1", {31'b0, v2}, 0);
    chk("flush_gone1d", o2, 0);
    tick;
    chk("flush_gone2", {31'b0, v2}, 0);
    sel = 1; in_valid = 1;
    tick;
    chk("bub_v1", {31'b0, v1}, 1);
    chk("bub_d1", o1, 32'hB1);
    in_valid = 0; sel = 3;
    tick;
    chk("bub_v0", {31'b0, v1}, 0);
    chk("bub_hold", o1, 32'hB1);
    in_valid = 1; sel = 2;
    tick;
    chk("bub_v2", {31'b0, v1}, 1);
    chk("bub_d2", o1, 32'hC2);
    sel = 3;
    tick;
    in_valid = 0;
    tick;
    chk("oor_valid", {31'b0, v3}, 1);
`ifdef MUX_PIPE_SELCHK_EN
    chk("oor_out", o3, 0);
    chk("oor_err", {31'b0, e3}, 1);
`else
    chk("oor_out", o3, 32'hA0);
    chk("oor_err", {31'b0, e3}, 0);
`endif
    chk("pow2_out", o2, 32'hD3);
    chk("pow2_err", {31'b0, e2}, 0);
    sel = 1; in_valid = 1;
    tick;
    tick;
    chk("pre_rst", {31'b0, v2}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_out", o2, 0);
    chk("arst_valid", {31'b0, v2}, 0);
    chk("arst_s1", {31'b0, v1}, 0);
    tick;
    rst_n = 1;
    tick;
    chk("rel_early", {31'b0, v2}, 0);
    chk("rel_s1", o1, 32'hB1);
    tick;
    chk("rel_out", o2, 32'hB1);
    chk("rel_valid", {31'b0, v2}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_pipe_nto1.md
MUX_PIPE_NTO1 -- requirements
Module: mux_pipe_nto1

Interface
REQ-001 Parameter WIDTH, default 32: data width per input lane, in bits.
REQ-002 Parameter NUM_IN, default 4: number of input lanes; legal range 2..16.
REQ-003 Parameter STAGES, default 1: register stages between input and output; legal range 1..4.
REQ-004 Parameter SEL_W, default 2: select width; SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-005 Clk  input  1  system clock; all state updates on rising edge.
REQ-006 Rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  lane select, sampled with in_data.
REQ-009 in_valid  input  1  qualifies in_data/sel in the current cycle.
REQ-010 stall  input  1  freeze all stages.
REQ-011 flush  input  1  invalidate and zero all stages.
REQ-012 out  output  WIDTH  registered selected lane from the last stage.
REQ-013 out_valid  output  1  out holds a valid selection.
REQ-014 sel_err  output  1  registered flag for an out-of-range select, aligned with out.

Function
REQ-015 Each stage SHALL hold data[WIDTH], valid and err; stage 0 loads from the inputs; stage i loads from stage i-1.
REQ-016 Stage 0 data SHALL load in_data lane sel when sel < NUM_IN.
REQ-017 Latency SHALL be exactly STAGES cycles from an accepted input to out/out_valid, with no stall.
REQ-018 While stall=1 and flush=0, every stage SHALL hold data, valid and err unchanged, and inputs SHALL be ignored.
REQ-019 When flush=1, every stage SHALL clear data to 0, valid to 0 and err to 0 on the next edge, regardless of stall.
REQ-020 Flush SHALL have priority over stall, and stall SHALL have priority over a normal load.
REQ-021 When in_valid=0 and the stage is not stalled, stage 0 SHALL load valid=0 and err=0, and SHALL retain its previous data.
REQ-022 Stages 1..STAGES-1 SHALL copy the previous stage's data, valid and err unconditionally when not stalled or flushed.
REQ-023 out, out_valid and sel_err SHALL come directly from the last stage, with no combinational path from the inputs.
REQ-024 With NUM_IN a power of two, no select value is out of range, and sel_err SHALL stay 0.

Reset
REQ-025 While Rst_n=0, every stage SHALL be cleared asynchronously: data=0, valid=0, err=0; therefore out=0, out_valid=0 and sel_err=0.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight entries.
REQ-027 The first load after Rst_n deasserts SHALL occur on the first rising edge with Rst_n=1.

Configuration
REQ-028 Macro MUX_PIPE_SELCHK_EN defined, and in_valid=1 with sel >= NUM_IN: stage 0 SHALL load data=0, valid=1 and err=1.
REQ-029 Macro MUX_PIPE_SELCHK_EN not defined: an out-of-range sel SHALL select lane 0 with err=0, and sel_err SHALL be tied to 0.

Verification
REQ-030 Basic selection: WIDTH=32, NUM_IN=4, STAGES=2; lanes={0xA0,0xB1,0xC2,0xD3}, sel=2, in_valid=1 at cycle 0 -> out=0xC2 and out_valid=1 at cycle 2, not before.
REQ-031 Stall hold: stream sel=0,1,2,3 on consecutive cycles, then stall=1 for 3 cycles -> out and out_valid constant during the stall, and the sequence resumes 0xA0,0xB1,0xC2,0xD3 with no loss or duplication.
REQ-032 Flush over stall: stall=1 and flush=1 in the same cycle with 2 entries in flight -> next cycle out=0, out_valid=0, and no flushed entry ever appears.
REQ-033 Out-of-range select: NUM_IN=3, SEL_W=2, sel=3, in_valid=1 -> with the macro, out=0, out_valid=1, sel_err=1 after STAGES cycles; without it, out=lane 0 and sel_err=0.
REQ-034 Async reset: drop Rst_n mid-cycle with out_valid=1 -> out=0 and out_valid=0 immediately, before the next Clk edge; after release, a sel=1 load gives out=0xB1 after STAGES cycles.
REQ-035 Bubble: in_valid=0 for one cycle between two valid loads -> out_valid shows 1,0,1 at the output, and out retains its prior value during the bubble (STAGES=1).
